imem_loader: RTL and testbench

Boot-time program loader for the RV32I core: accepts a framed byte stream over a valid/ready interface, assembles little-endian 32-bit words and writes them sequentially into instruction memory from word address 0. It is the write side of instruction memory, whose read side is the core's fetch stage. It holds the core in reset until a complete, valid image has been written.

---
 rtl/imem_loader.sv | 218 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream (A5, N lo, N hi, 4*N payload bytes) -> sequential
// instruction-memory word writes; holds the core in reset until the image is in.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
`ifdef LOADER_CHECKSUM_EN
        , S_CSUM = 3'd6
`endif
    } state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    // Largest legal word count; 17 bits so a full 16-bit N can be compared against it.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [16:0]       remaining_q, remaining_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_hold_q, core_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic        accept;
    logic [15:0] len_word;

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:                             rx_ready = 1'b1;
`endif
            default:                            rx_ready = 1'b0;
        endcase
    end

    assign accept   = rx_valid & rx_ready;
    assign len_word = {rx_data, len_lo_q};

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        remaining_d  = remaining_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        addr_d       = addr_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        done_d       = done_q;
        err_d        = err_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        // Release the core one cycle after done rises, so the final write lands first.
        core_hold_d  = done_q ? 1'b0 : core_hold_q;

        case (state_q)
            S_IDLE: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                if (accept) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN_HI;
                end
            end

            S_LEN_HI: begin
                if (accept) begin
                    if (len_word == 16'd0 || {1'b0, len_word} > MAX_WORDS) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = S_DATA;
                        remaining_d = {1'b0, len_word};
                        byte_cnt_d  = 2'd0;
                        addr_d      = '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_d      = 8'd0;
`endif
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = addr_q;
                        imem_wdata_d = {rx_data, shift_q};
                        addr_d       = addr_q + 1'b1;
                        remaining_d  = remaining_q - 17'd1;
                        if (remaining_q == 17'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
                            done_d  = 1'b1;
`endif
                        end
                    end else begin
                        // Little-endian: earliest byte ends up in the low bits.
                        shift_d = {rx_data, shift_q[23:8]};
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif

            S_DONE, S_ERR: begin
                if (restart) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    addr_d      = '0;
                    imem_addr_d = '0;
                    core_hold_d = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            len_lo_q     <= 8'd0;
            remaining_q  <= 17'd0;
            byte_cnt_q   <= 2'd0;
            shift_q      <= 24'd0;
            addr_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            core_hold_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            remaining_q  <= remaining_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_hold_q  <= core_hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_hold  = core_hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=4); follows LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              restart = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          b2b_we   = 0;
    logic        prev_we  = 1'b0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  stim[$];

    // Write monitor on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(32'(imem_addr));
            wr_data_q.push_back(imem_wdata);
        end
        if (imem_we && prev_we) b2b_we++;
        prev_we = imem_we;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        b2b_we = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!rx_ready) begin
            check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_stim(input int max_gap);
        foreach (stim[i]) begin
            int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
            send_byte(stim[i]);
        end
    endtask

    task automatic load_basic();
        stim = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88};
    endtask

    task automatic check_writes(input string tag, input int n,
                                input logic [31:0] d0, input logic [31:0] d1);
        check({tag, "_nwrites"}, 32'(wr_data_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_data_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], 32'(i));
            check($sformatf("%s_data%0d", tag, i), wr_data_q[i], (i == 0) ? d0 : d1);
        end
    endtask

    task automatic do_restart();
        restart  = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        @(posedge clk); #1;
        restart  = 1'b0;
        rx_valid = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready",  {31'd0, rx_ready},  32'd1);
        check("rst_imem_we",   {31'd0, imem_we},   32'd0);
        check("rst_imem_addr", 32'(imem_addr),     32'd0);
        check("rst_wdata",     imem_wdata,         32'd0);
        check("rst_core_hold", {31'd0, core_hold}, 32'd1);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_err",       {31'd0, err},       32'd0);
        rst = 1'b1;

        // Basic load
        clear_log();
        load_basic();
        send_stim(0);
`ifdef LOADER_CHECKSUM_EN
        check("basic_we_last",        {31'd0, imem_we}, 32'd1);
        check("basic_done_pre_csum",  {31'd0, done},    32'd0);
        stim = '{8'h88};
        send_stim(0);
        check("basic_done_after_csum", {31'd0, done},      32'd1);
        check("basic_hold_with_done",  {31'd0, core_hold}, 32'd1);
`else
        check("basic_we_last",        {31'd0, imem_we},   32'd1);
        check("basic_done_with_we",   {31'd0, done},      32'd1);
        check("basic_hold_with_done", {31'd0, core_hold}, 32'd1);
`endif
        @(posedge clk); #1;
        check("basic_hold_released", {31'd0, core_hold}, 32'd0);
        check("basic_done_held",     {31'd0, done},      32'd1);
        check("basic_rx_ready_done", {31'd0, rx_ready},  32'd0);
        check("basic_we_single",     {31'd0, imem_we},   32'd0);
        check_writes("basic", 2, 32'h44332211, 32'h88776655);
        do_restart();
        check("restart_done",      {31'd0, done},      32'd0);
        check("restart_err",       {31'd0, err},       32'd0);
        check("restart_rx_ready",  {31'd0, rx_ready},  32'd1);
        check("restart_core_hold", {31'd0, core_hold}, 32'd1);
        check("restart_addr",      32'(imem_addr),     32'd0);

        // Sync hunt
        clear_log();
        stim = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'h22);
`endif
        send_stim(0);
        @(posedge clk); #1;
        check("hunt_done", {31'd0, done}, 32'd1);
        check_writes("hunt", 1, 32'hEFBEADDE, 32'h0);
        do_restart();

        // Length zero
        clear_log();
        stim = '{8'hA5, 8'h00, 8'h00};
        send_stim(0);
        check("len0_err",       {31'd0, err},       32'd1);
        check("len0_core_hold", {31'd0, core_hold}, 32'd1);
        check("len0_rx_ready",  {31'd0, rx_ready},  32'd0);
        check("len0_done",      {31'd0, done},      32'd0);
        @(posedge clk); #1;
        check_writes("len0", 0, 32'h0, 32'h0);
        do_restart();
        check("len0_restart_err",      {31'd0, err},      32'd0);
        check("len0_restart_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Length 17 exceeds 2**4 words
        clear_log();
        stim = '{8'hA5, 8'h11, 8'h00};
        send_stim(0);
        check("len17_err", {31'd0, err}, 32'd1);
        @(posedge clk); #1;
        check("len17_core_hold", {31'd0, core_hold}, 32'd1);
        check_writes("len17", 0, 32'h0, 32'h0);
        do_restart();
        check("len17_restart_err",      {31'd0, err},      32'd0);
        check("len17_restart_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Length 16 accepted, then reset after 6 payload bytes
        clear_log();
        stim = '{8'hA5, 8'h10, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_stim(0);
        check("len16_err",      {31'd0, err},      32'd0);
        check("len16_rx_ready", {31'd0, rx_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_we",        {31'd0, imem_we},   32'd0);
        check("midrst_addr",      32'(imem_addr),     32'd0);
        check("midrst_core_hold", {31'd0, core_hold}, 32'd1);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_writes("midrst", 1, 32'h44332211, 32'h0);
        clear_log();
        load_basic();
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'h88);
`endif
        send_stim(0);
        @(posedge clk); #1;
        check("after_rst_done", {31'd0, done}, 32'd1);
        check_writes("after_rst", 2, 32'h44332211, 32'h88776655);
        do_restart();

        // Backpressure: random 0-3 cycle gaps
        clear_log();
        load_basic();
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'h88);
`endif
        send_stim(3);
        repeat (2) @(posedge clk);
        #1;
        check("bp_done",   {31'd0, done}, 32'd1);
        check("bp_b2b_we", 32'(b2b_we),   32'd0);
        check_writes("bp", 2, 32'h44332211, 32'h88776655);
        do_restart();

`ifdef LOADER_CHECKSUM_EN
        // Checksum mismatch
        clear_log();
        load_basic();
        stim.push_back(8'h89);
        send_stim(0);
        check("csum_err",  {31'd0, err},  32'd1);
        check("csum_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        check("csum_core_hold", {31'd0, core_hold}, 32'd1);
        check_writes("csum", 2, 32'h44332211, 32'h88776655);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
